// File: rtl/btn_event_scheduler.sv
// Turns five debounced button levels into a prioritised stream of press / auto-repeat events,
// buffered in a small FIFO and handed out on a valid/ready handshake.
module btn_event_scheduler #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       debounced_btnC,
   input  logic       debounced_btnU,
   input  logic       debounced_btnD,
   input  logic       debounced_btnL,
   input  logic       debounced_btnR,
   input  logic       repeat_en,
   input  logic       evt_ready,
   input  logic       ovf_clr,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic       evt_repeat,
   output logic       evt_overflow
);

   localparam int unsigned NumBtn = 5;
   localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CntW   = $clog2(MaxCnt);
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
   localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StWaitRel, StIdle, StHeld, StRpt} btn_state_e;

   logic [NumBtn-1:0] btn;
   btn_state_e        state_q [NumBtn];
   btn_state_e        state_d [NumBtn];
   logic [CntW-1:0]   cnt_q [NumBtn];
   logic [CntW-1:0]   cnt_d [NumBtn];
   logic [NumBtn-1:0] req, req_rpt;

   logic [NumBtn-1:0] pend_q, pend_d, prpt_q, prpt_d;
   logic [NumBtn-1:0] grant, grant_eff, accept, drop;
   logic [2:0]        sel_code;
   logic              sel_rpt;
   logic              ovf_q, ovf_d;

   logic [3:0]        mem_q [FIFO_DEPTH];
   logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
   logic              empty, full, push, pop;
   logic [3:0]        head;

   // Index order doubles as priority and event code: C=0 .. R=4.
   assign btn = {debounced_btnR, debounced_btnL, debounced_btnD, debounced_btnU, debounced_btnC};

   always_comb begin
      for (int i = 0; i < NumBtn; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         req[i]     = 1'b0;
         req_rpt[i] = 1'b0;
         case (state_q[i])
            StWaitRel: if (!btn[i]) state_d[i] = StIdle;
            StIdle: begin
               if (btn[i]) begin
                  state_d[i] = StHeld;
                  req[i]     = 1'b1;
                  cnt_d[i]   = '0;
               end
            end
            StHeld: begin
               if (!btn[i]) begin
                  state_d[i] = StIdle;
               end else if (cnt_q[i] == DelayLast) begin
                  // Counter parks at the last value while repeat is disabled.
                  if (repeat_en) begin
                     state_d[i] = StRpt;
                     req[i]     = 1'b1;
                     req_rpt[i] = 1'b1;
                     cnt_d[i]   = '0;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
            StRpt: begin
               if (!btn[i]) begin
                  state_d[i] = StIdle;
               end else if (cnt_q[i] == PeriodLast) begin
                  req[i]     = repeat_en;
                  req_rpt[i] = 1'b1;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
            default: state_d[i] = StWaitRel;
         endcase
      end
   end

   always_comb begin
      grant    = '0;
      sel_code = '0;
      sel_rpt  = 1'b0;
      for (int i = NumBtn - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            sel_code = 3'(i);
            sel_rpt  = prpt_q[i];
         end
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign pop   = !empty && evt_ready;
   assign push  = (|pend_q) && (!full || pop);

   // A slot being drained this cycle may be refilled by a fresh request without overflow.
   assign grant_eff = push ? grant : '0;
   assign drop      = req & pend_q & ~grant_eff;
   assign accept    = req & ~drop;
   assign pend_d    = accept | (pend_q & ~grant_eff);
   assign prpt_d    = (accept & req_rpt) | (~accept & prpt_q);
   assign ovf_d     = (|drop) | (ovf_q & !ovf_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumBtn; i++) begin
            state_q[i] <= StWaitRel;
            cnt_q[i]   <= '0;
         end
         pend_q   <= '0;
         prpt_q   <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         for (int i = 0; i < NumBtn; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         pend_q <= pend_d;
         prpt_q <= prpt_d;
         ovf_q  <= ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {sel_code, sel_rpt};
   end

   assign head         = mem_q[rd_ptr_q[PtrW-1:0]];
   assign evt_valid    = !empty;
   assign evt_code     = evt_valid ? head[3:1] : 3'd0;
   assign evt_repeat   = evt_valid ? head[0] : 1'b0;
   assign evt_overflow = ovf_q;

endmodule
